// File: rtl/inc_clk_meter.sv
// inc_clk_meter
//   Receive-side meter for a divided toggle clock. clk_in is synchronized into
//   the clk domain, and each toggle (rising or falling) is one edge. The meter
//   counts clk cycles between edges. It reports the interval as half_period and
//   recovers the divider factor as half_period-2. The divider output toggles
//   every factor+2 source cycles.
//
// Ports
//   clk          fast sampling clock (all logic here)
//   rst          synchronous active-high reset
//   clk_in       divided toggle signal, asynchronous to clk
//   meas_en      1 = measure, 0 = go idle and clear sticky flags
//   half_period  clk cycles between the last two detected toggles
//   factor_est   half_period-2, saturating at 0
//   meas_valid   new measurement pending (valid/ready handshake)
//   meas_ready   consumer accepts when meas_valid && meas_ready
//   meas_stable  last two captured half_period values were equal
//   overrun      sticky: an unaccepted measurement was overwritten
//   stalled      no toggle seen for TIMEOUT cycles
module inc_clk_meter #(
    parameter int          SYNC_STAGES = 2,
    parameter int          CNT_W       = 32,
    parameter logic [31:0] TIMEOUT     = 32'd1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] half_period,
    output logic [CNT_W-1:0] factor_est,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             meas_stable,
    output logic             overrun,
    output logic             stalled
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARM   = 2'd1;
    localparam logic [1:0] S_MEAS  = 2'd2;
    localparam logic [1:0] S_STALL = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 32'd1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   tgl_edge;
    logic [1:0]             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_inc;
    logic [CNT_W-1:0]       cap_fe;
    logic                   have_prev_q;

    // Synchronizer plus one edge-detect flop. Both toggle directions count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tgl_edge = sync_q[SYNC_STAGES-1] ^ prev_q;

    // The saturating count+1 is also the captured interval. The counter is
    // cleared on the edge cycle itself, so the cycle holding the edge must be
    // counted as part of the interval.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign cap_fe  = (cnt_inc < TWO) ? '0 : cnt_inc - TWO;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            half_period <= '0;
            factor_est  <= '0;
            meas_valid  <= 1'b0;
            meas_stable <= 1'b0;
            overrun     <= 1'b0;
            stalled     <= 1'b0;
            have_prev_q <= 1'b0;
        end else if (!meas_en) begin
            // Going idle keeps the last measurement but drops all status.
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            meas_valid  <= 1'b0;
            meas_stable <= 1'b0;
            overrun     <= 1'b0;
            stalled     <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            // Consumer acceptance. A capture in the same cycle overrides this
            // below and keeps meas_valid high.
            if (meas_valid && meas_ready)
                meas_valid <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    cnt_q   <= '0;
                    state_q <= S_ARM;
                end
                S_ARM: begin
                    // The interval up to the first edge is partial, so it is discarded.
                    cnt_q       <= tgl_edge ? '0 : cnt_inc;
                    have_prev_q <= 1'b0;
                    if (tgl_edge)
                        state_q <= S_MEAS;
                end
                S_MEAS: begin
                    cnt_q <= tgl_edge ? '0 : cnt_inc;
                    if (tgl_edge) begin
                        half_period <= cnt_inc;
                        factor_est  <= cap_fe;
                        meas_valid  <= 1'b1;
                        if (meas_valid && !meas_ready)
                            overrun <= 1'b1;
                        // half_period still holds the previous capture here.
                        meas_stable <= have_prev_q && (cnt_inc == half_period);
                        have_prev_q <= 1'b1;
                    end else if (cnt_q >= TO_LAST) begin
                        state_q     <= S_STALL;
                        stalled     <= 1'b1;
                        meas_stable <= 1'b0;
                        have_prev_q <= 1'b0;
                    end
                end
                default: begin // S_STALL
                    // The first edge after a stall ends an interval of unknown
                    // length, so it only restarts measurement.
                    cnt_q <= tgl_edge ? '0 : cnt_inc;
                    if (tgl_edge) begin
                        state_q     <= S_MEAS;
                        stalled     <= 1'b0;
                        have_prev_q <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inc_clk_meter.sv
module tb_inc_clk_meter;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             clk_in;
    logic             meas_en;
    logic             meas_ready;
    logic [CNT_W-1:0] half_period;
    logic [CNT_W-1:0] factor_est;
    logic             meas_valid;
    logic             meas_stable;
    logic             overrun;
    logic             stalled;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    inc_clk_meter #(
        .SYNC_STAGES(2),
        .CNT_W      (CNT_W),
        .TIMEOUT    (32'd100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_in     (clk_in),
        .meas_en    (meas_en),
        .half_period(half_period),
        .factor_est (factor_est),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .meas_stable(meas_stable),
        .overrun    (overrun),
        .stalled    (stalled)
    );

    // One toggle of clk_in, gap cycles after the previous one. Outputs are
    // checked 3 cycles after the toggle, once the capture is visible.
    typedef struct {
        int          gap;
        bit          ready;
        logic [31:0] hp;
        logic [31:0] fe;
        bit          vld;
        bit          stb;
        bit          ovr;
        bit          stl;
    } vec_t;

    vec_t tbl[9];

    task automatic waitn(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".half_period"}, half_period, v.hp);
        chk({tag, ".factor_est"},  factor_est,  v.fe);
        chk({tag, ".meas_valid"},  32'(meas_valid),  32'(v.vld));
        chk({tag, ".meas_stable"}, 32'(meas_stable), 32'(v.stb));
        chk({tag, ".overrun"},     32'(overrun),     32'(v.ovr));
        chk({tag, ".stalled"},     32'(stalled),     32'(v.stl));
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        waitn(v.gap - 3);
        meas_ready = v.ready;
        clk_in     = ~clk_in;
        waitn(3);
        chk_all(tag, v);
    endtask

    initial begin
        vec_t v;
        int   cnt;

        //          gap rdy  hp  fe  vld stb ovr stl
        tbl[0] = '{7,  1,  0,  0,  0,  0,  0,  0}; // ARM: first edge discarded
        tbl[1] = '{7,  1,  7,  5,  1,  0,  0,  0}; // first capture, no predecessor
        tbl[2] = '{7,  1,  7,  5,  1,  1,  0,  0};
        tbl[3] = '{7,  1,  7,  5,  1,  1,  0,  0};
        tbl[4] = '{10, 1, 10,  8,  1,  0,  0,  0}; // factor 5 -> 8
        tbl[5] = '{10, 1, 10,  8,  1,  1,  0,  0};
        tbl[6] = '{12, 0, 12, 10,  1,  0,  0,  0}; // ready low from here
        tbl[7] = '{12, 0, 12, 10,  1,  1,  1,  0}; // overwrite while pending
        tbl[8] = '{12, 0, 12, 10,  1,  1,  1,  0};

        rst = 1'b1; clk_in = 1'b0; meas_en = 1'b0; meas_ready = 1'b1;
        waitn(3);
        v = '{0, 1, 0, 0, 0, 0, 0, 0};
        chk_all("reset", v);
        rst = 1'b0; meas_en = 1'b1;
        waitn(2);

        for (int i = 0; i < 9; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

        // Accept the held measurement; valid falls, overrun stays sticky.
        meas_ready = 1'b1;
        waitn(1);
        v = '{0, 1, 12, 10, 0, 1, 1, 0};
        chk_all("accept", v);

        // meas_en low: status cleared, data retained.
        meas_en = 1'b0;
        waitn(2);
        v = '{0, 1, 12, 10, 0, 0, 0, 0};
        chk_all("disable", v);

        // factor 0: toggle every 2 cycles.
        meas_en = 1'b1;
        waitn(2);
        for (int i = 0; i < 8; i++) begin
            clk_in = ~clk_in;
            waitn(2);
        end
        waitn(1);
        chk("f0.half_period", half_period, 32'd2);
        chk("f0.factor_est",  factor_est,  32'd0);
        chk("f0.meas_stable", 32'(meas_stable), 32'd1);
        chk("f0.overrun",     32'(overrun),     32'd0);

        // Toggle every cycle: capture and accept coincide every cycle.
        for (int i = 0; i < 10; i++) begin
            clk_in = ~clk_in;
            waitn(1);
        end
        waitn(2);
        v = '{0, 1, 1, 0, 1, 1, 0, 0};
        chk_all("fast", v);

        // Freeze clk_in: stalled rises 100 cycles after the last edge
        // (edge is acted on 3 cycles after the toggle).
        cnt = 3;
        while (!stalled && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        chk("stall.delay", 32'(cnt), 32'd103);
        chk("stall.meas_stable", 32'(meas_stable), 32'd0);
        chk("stall.meas_valid",  32'(meas_valid),  32'd0);

        // Resume: first edge restarts without capture, second captures.
        v = '{10, 1, 1, 0, 0, 0, 0, 0};
        run_vec("resume0", v);
        v = '{7, 1, 7, 5, 1, 0, 0, 0};
        run_vec("resume1", v);
        v = '{7, 0, 7, 5, 1, 1, 0, 0};
        run_vec("resume2", v);

        // Reset mid-measurement with meas_valid=1.
        rst = 1'b1; clk_in = 1'b0;
        waitn(1);
        v = '{0, 0, 0, 0, 0, 0, 0, 0};
        chk_all("midrst", v);
        waitn(1);
        rst = 1'b0; meas_ready = 1'b1;
        waitn(1);
        v = '{10, 1, 0, 0, 0, 0, 0, 0};
        run_vec("post0", v);
        v = '{7, 1, 7, 5, 1, 0, 0, 0};
        run_vec("post1", v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
